// File: rtl/seg7_scan_decoder.sv
// Purpose: reads back a multiplexed active-low 8-digit 7-segment display into a 32-bit hex value.
// Latency: inputs stable from edge 0 are captured at edge SETTLE_CYCLES+2; frame_done follows one cycle later.
// Backpressure: none; each stable input interval is evaluated exactly once, and shorter holds are ignored.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  output logic [31:0] digits,
  output logic [7:0]  dp_seen,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        bad_pattern,
  output logic        bad_anode
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // The count reaches SETTLE_CYCLES-1 once the bus has been stable for SETTLE_CYCLES samples.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;
  // Reset image of the sampled bus: all anodes off, all segments dark, DP dark.
  localparam logic [15:0] BUS_IDLE    = 16'hFFFF;

  // Sampled bus layout: {AN[7:0], CA, CB, CC, CD, CE, CF, CG, DP}, segment a at bit 7.
  logic [15:0] s_in_d, s_in_q;
  logic [15:0] s_prev_d, s_prev_q;
  logic [15:0] cnt_d, cnt_q;
  state_e      state_d, state_q;

  logic [31:0] digits_d, digits_q;
  logic [7:0]  dp_seen_d, dp_seen_q;
  logic [7:0]  digit_valid_d, digit_valid_q;
  logic        frame_done_d, frame_done_q;
  logic        bad_pattern_d, bad_pattern_q;
  logic        bad_anode_d, bad_anode_q;

  logic        in_changed;
  logic [7:0]  an_sel;
  logic [6:0]  seg_lit;
  logic        dp_lit;
  logic        an_any;
  logic        an_multi;
  logic [2:0]  an_idx;
  logic        pat_ok;
  logic [3:0]  pat_nib;

  // Input stage: one register to sample the pins, a second copy to detect changes.
  always_comb begin
    s_in_d   = {AN, CA, CB, CC, CD, CE, CF, CG, DP};
    s_prev_d = s_in_q;
  end

  assign in_changed = (s_in_q != s_prev_q);

  // Stability counter: restarts on any change of the sampled bus, otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (in_changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Settle FSM: a change always restarts the wait; a settled interval is evaluated once, then held.
  always_comb begin
    state_d = state_q;
    if (in_changed) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: if (cnt_q >= SETTLE_LAST) state_d = ST_EVAL;
        ST_EVAL: state_d = ST_HOLD;
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // The evaluated value is s_prev: it equals the settled bus even when a new change lands in the EVAL cycle.
  assign an_sel  = ~s_prev_q[15:8];
  assign seg_lit = ~s_prev_q[7:1];
  assign dp_lit  = ~s_prev_q[0];

  // Anode classification: none selected, exactly one selected (with its index), or several selected.
  always_comb begin
    an_any   = |an_sel;
    an_multi = ((an_sel & (an_sel - 8'd1)) != 8'd0);
    an_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_sel[i]) an_idx = 3'(i);
    end
  end

  // Segment decode, lit segments listed as {a,b,c,d,e,f,g}; anything else is an illegal pattern.
  always_comb begin
    pat_ok  = 1'b1;
    pat_nib = 4'h0;
    case (seg_lit)
      7'b1111110: pat_nib = 4'h0;
      7'b0110000: pat_nib = 4'h1;
      7'b1101101: pat_nib = 4'h2;
      7'b1111001: pat_nib = 4'h3;
      7'b0110011: pat_nib = 4'h4;
      7'b1011011: pat_nib = 4'h5;
      7'b1011111: pat_nib = 4'h6;
      7'b1110000: pat_nib = 4'h7;
      7'b1111111: pat_nib = 4'h8;
      7'b1110011: pat_nib = 4'h9;
      7'b1110111: pat_nib = 4'hA;
      7'b0011111: pat_nib = 4'hB;
      7'b0001101: pat_nib = 4'hC;
      7'b0111101: pat_nib = 4'hD;
      7'b1001111: pat_nib = 4'hE;
      7'b1000111: pat_nib = 4'hF;
      default:    pat_ok  = 1'b0;
    endcase
  end

  // Capture, error pulses and frame bookkeeping; frame_done fires the cycle after valid fills, then valid clears.
  always_comb begin
    digits_d      = digits_q;
    dp_seen_d     = dp_seen_q;
    digit_valid_d = digit_valid_q;
    frame_done_d  = 1'b0;
    bad_pattern_d = 1'b0;
    bad_anode_d   = 1'b0;

    if (frame_done_q) begin
      digit_valid_d = 8'h00;
    end else if (digit_valid_q == 8'hFF) begin
      frame_done_d = 1'b1;
    end

    if ((state_q == ST_EVAL) && an_any) begin
      if (an_multi) begin
        bad_anode_d = 1'b1;
      end else if (!pat_ok) begin
        bad_pattern_d = 1'b1;
      end else begin
        digits_d[{an_idx, 2'b00} +: 4] = pat_nib;
        dp_seen_d[an_idx]              = dp_lit;
        digit_valid_d[an_idx]          = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      s_in_q        <= BUS_IDLE;
      s_prev_q      <= BUS_IDLE;
      cnt_q         <= '0;
      state_q       <= ST_WAIT;
      digits_q      <= '0;
      dp_seen_q     <= '0;
      digit_valid_q <= '0;
      frame_done_q  <= 1'b0;
      bad_pattern_q <= 1'b0;
      bad_anode_q   <= 1'b0;
    end else begin
      s_in_q        <= s_in_d;
      s_prev_q      <= s_prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      digits_q      <= digits_d;
      dp_seen_q     <= dp_seen_d;
      digit_valid_q <= digit_valid_d;
      frame_done_q  <= frame_done_d;
      bad_pattern_q <= bad_pattern_d;
      bad_anode_q   <= bad_anode_d;
    end
  end

  assign digits      = digits_q;
  assign dp_seen     = dp_seen_q;
  assign digit_valid = digit_valid_q;
  assign frame_done  = frame_done_q;
  assign bad_pattern = bad_pattern_q;
  assign bad_anode   = bad_anode_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side companion to the 7-segment encoder and display path. It watches the multiplexed, active-low anode and segment lines of the 8-digit display, waits for each lit digit to settle, and decodes the segment pattern back to a hex nibble. It rebuilds the full 32-bit displayed value and flags illegal patterns and anode states. It sits beside the display driver for on-board self-check, or it can be driven from header pins to read back another board's display.

## Interface
- SETTLE_CYCLES, 16, consecutive cycles that {AN, CA..CG, DP} must hold unchanged before a digit is sampled. Legal range 2..65535; the stability counter is 16 bits.
- CLK100MHZ  in  1  system clock, all logic on the rising edge
- CPU_RESETN  in  1  reset, synchronous, active-low
- AN  in  8  anodes, active-low; AN[i] low selects digit i
- CA, CB, CC, CD, CE, CF, CG  in  1 each  segments a..g, active-low
- DP  in  1  decimal point, active-low
- digits  out  32  digits[4i+3:4i] holds the last decoded nibble of digit i
- dp_seen  out  8  dp_seen[i] holds the last DP state of digit i (1 = lit)
- digit_valid  out  8  bit i set once digit i has been captured in the current frame
- frame_done  out  1  one-cycle pulse when all 8 digits have been captured
- bad_pattern  out  1  one-cycle pulse: a settled pattern is not in the decode table
- bad_anode  out  1  one-cycle pulse: a settled AN has two or more low bits

## Operation
- Input stage: register {AN, CA..CG, DP} once (s_in), and keep a previous copy (s_prev).
- Stability counter: cleared when s_in != s_prev, otherwise incremented, saturating.
- FSM states:
  - WAIT: stability counter running.
  - EVAL: inputs have been stable for SETTLE_CYCLES; evaluate them.
  - HOLD: evaluated; wait for an input change.
- FSM transitions:
  - Any input change in any state moves to WAIT and clears the counter.
  - WAIT moves to EVAL when the count reaches SETTLE_CYCLES-1.
  - EVAL moves to HOLD after one cycle.
- Result: each stable interval produces exactly one evaluation, however long it lasts.
- EVAL actions:
  - AN == 8'hFF (blanked): no action.
  - Two or more AN bits low: pulse bad_anode; no capture.
  - Exactly one AN bit (i) low and the segment set is in the table: write the nibble to digits[i], write ~DP to dp_seen[i], set digit_valid[i].
  - Exactly one AN bit low and the segment set is not in the table: pulse bad_pattern; digits[i], dp_seen[i] and digit_valid[i] are unchanged.
- Decode table, listing the lit segments (wire level low):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcfg, A=abcefg, b=cdefg, C=deg, d=bcdeg, E=adefg, F=aefg
- Re-capture: capturing a digit that is already valid overwrites its value and does not double-count.
- Frame completion: the cycle after the capture that makes digit_valid 8'hFF, frame_done pulses with digit_valid still 8'hFF. On the next cycle digit_valid clears to 8'h00. digits and dp_seen persist.
- Reset: CPU_RESETN low at an edge puts every output at 0, puts the FSM in WAIT and clears the counter. This applies mid-frame and mid-settle. No partial-frame state survives.

## Timing
- Reset values: digits=0, dp_seen=0, digit_valid=0, frame_done=0, bad_pattern=0, bad_anode=0.
- Capture latency: inputs change before edge 0 and then hold. digits, dp_seen, digit_valid and the error pulses update at edge SETTLE_CYCLES+2.
- Glitch rejection: any hold shorter than SETTLE_CYCLES+1 cycles produces no capture and no error pulse.
- Pulse width: all pulses are exactly one cycle. frame_done and an error pulse never coincide, because frame_done follows a capture.
- Simultaneous events: the frame-completing capture and a change of input at the same edge have no interaction; frame_done still fires.
- Throughput: one evaluation per stable interval. There is no other back-pressure.

## Test plan
- Reset: hold CPU_RESETN=0 for 3 cycles with random inputs -> all outputs 0. Release with AN=8'hFF held -> no pulses.
- Full frame: SETTLE_CYCLES=16; scan AN[7]..AN[0] showing 1,2,3,4,A,b,C,d, each for 20 cycles -> digits=32'h1234ABCD and exactly one frame_done. On the frame_done cycle digit_valid=8'hFF; on the next cycle it is 8'h00.
- Glitch: drive digit 3 with "8" for 16 cycles, then switch -> no capture. Hold for 17 cycles -> capture at edge 18 after the change.
- Bad pattern: AN=8'hFE with only segment a lit, 20 cycles -> one bad_pattern pulse; digits[3:0] and digit_valid[0] are unchanged.
- Bad anode: AN=8'hFC with a legal "5", 20 cycles -> one bad_anode pulse; no capture.
- Reset mid-frame: capture digits 0-3, then pulse CPU_RESETN low for 1 cycle -> digits=0 and digit_valid=0. frame_done then requires all 8 digits to be captured again.
